// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, fetch-strobe and fill-state definitions for the CPU datapath
package cpu_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_OPC_W  = 3;
  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] LDA = 3'b001;
  localparam logic [2:0] STO = 3'b010;
  localparam logic [2:0] ADD = 3'b011;
  localparam logic [2:0] AND = 3'b100;
  localparam logic [2:0] XOR = 3'b101;
  localparam logic [2:0] JMP = 3'b110;
  localparam logic [2:0] HLT = 3'b111;
  localparam logic [1:0] FETCH_HOLD = 2'b00;
  localparam logic [1:0] FETCH_OPC  = 2'b01;
  localparam logic [1:0] FETCH_OPR  = 2'b10;
  localparam logic [1:0] FETCH_ILL  = 2'b11;
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } fill_t;
endpackage

// File: rtl/ins_fetch_reg_err_tracker.sv
// ifr_err_tracker: sticky sequencing-error flag where a new error outranks a same-cycle clear
module ifr_err_tracker (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic seq_err
);
  logic seq_err_q, seq_err_d;
  // set beats clear so an error arriving with the clear is never lost
  always_comb seq_err_d = set ? 1'b1 : clr ? 1'b0 : seq_err_q;
  // flag register, cleared only by reset or clr
  always_ff @(posedge clk or negedge rst)
    if (!rst) seq_err_q <= 1'b0;
    else seq_err_q <= seq_err_d;
  assign seq_err = seq_err_q;
endmodule

// File: rtl/ins_fetch_reg.sv
// ins_fetch_reg: opcode/operand instruction register with fill tracking; IFR_INSTR_COUNT_EN adds an opcode-load counter
module ins_fetch_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W,
  localparam int ADDR_W = 2 * DATA_W - OPC_W
`ifdef IFR_INSTR_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [1:0]        fetch,
  input  logic [DATA_W-1:0] data,
  input  logic              clr_err,
  output logic [OPC_W-1:0]  ins,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              ins_valid,
  output logic              addr_valid,
  output logic              seq_err
`ifdef IFR_INSTR_COUNT_EN
  , output logic [CNT_W-1:0] instr_cnt
`endif
);
  localparam int HI_W = DATA_W - OPC_W;
  fill_t             state_q, state_d;
  logic [OPC_W-1:0]  ins_q, ins_d;
  logic [HI_W-1:0]   ad_hi_q, ad_hi_d;
  logic [DATA_W-1:0] ad_lo_q, ad_lo_d;
  logic opc_ld, opr_ld, err_set;
  assign opc_ld  = ena && fetch == FETCH_OPC;
  assign opr_ld  = ena && fetch == FETCH_OPR && state_q != EMPTY;
  assign err_set = ena && (fetch == FETCH_ILL || (fetch == FETCH_OPR && state_q == EMPTY));
  // fill state register; reset discards any partially fetched instruction
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= EMPTY;
    else state_q <= state_d;
  // opcode load always restarts at HALF; operand load only completes a started fetch
  always_comb state_d = opc_ld ? HALF : opr_ld ? FULL : state_q;
  // status outputs decoded from the registered state
  always_comb begin
    ins_valid  = state_q != EMPTY;
    addr_valid = state_q == FULL;
  end
  // opcode byte splits into opcode and high address bits; operand byte is the low address
  always_comb begin
    ins_d   = opc_ld ? data[DATA_W-1 -: OPC_W] : ins_q;
    ad_hi_d = opc_ld ? data[HI_W-1:0] : ad_hi_q;
    ad_lo_d = opr_ld ? data : ad_lo_q;
  end
  // instruction and address byte registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ins_q   <= NOP;
      ad_hi_q <= '0;
      ad_lo_q <= '0;
    end else begin
      ins_q   <= ins_d;
      ad_hi_q <= ad_hi_d;
      ad_lo_q <= ad_lo_d;
    end
  assign ins     = ins_q;
  assign ir_addr = {ad_hi_q, ad_lo_q};
  ifr_err_tracker u_err (
    .clk     (clk),
    .rst     (rst),
    .set     (err_set),
    .clr     (clr_err),
    .seq_err (seq_err)
  );
`ifdef IFR_INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // counts every accepted opcode load, wrapping silently
  always_comb cnt_d = opc_ld ? cnt_q + 1'b1 : cnt_q;
  // counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign instr_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_ins_fetch_reg.sv
// tb_ins_fetch_reg: table-driven directed checks of the instruction fetch register
module tb_ins_fetch_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic [1:0]  fetch = 2'b00;
  logic [7:0]  data = 8'h00;
  logic        clr_err = 1'b0;
  logic [2:0]  ins;
  logic [12:0] ir_addr;
  logic        ins_valid, addr_valid, seq_err;
  int checks = 0;
  int errors = 0;
`ifdef IFR_INSTR_COUNT_EN
  logic [1:0] instr_cnt;
  ins_fetch_reg #(.CNT_W(2)) dut (
`else
  ins_fetch_reg dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .fetch      (fetch),
    .data       (data),
    .clr_err    (clr_err),
    .ins        (ins),
    .ir_addr    (ir_addr),
    .ins_valid  (ins_valid),
    .addr_valid (addr_valid),
    .seq_err    (seq_err)
`ifdef IFR_INSTR_COUNT_EN
    , .instr_cnt (instr_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rs;
    logic        ena;
    logic [1:0]  fetch;
    logic [7:0]  data;
    logic        clr;
    logic [2:0]  e_ins;
    logic [12:0] e_addr;
    logic        e_iv;
    logic        e_av;
    logic        e_err;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag, input logic [2:0] e_ins, input logic [12:0] e_addr,
                         input logic e_iv, input logic e_av, input logic e_err);
    chk({tag, ".ins"}, 32'(ins), 32'(e_ins));
    chk({tag, ".ir_addr"}, 32'(ir_addr), 32'(e_addr));
    chk({tag, ".ins_valid"}, 32'(ins_valid), 32'(e_iv));
    chk({tag, ".addr_valid"}, 32'(addr_valid), 32'(e_av));
    chk({tag, ".seq_err"}, 32'(seq_err), 32'(e_err));
  endtask
  task automatic step(input logic e, input logic [1:0] f, input logic [7:0] d, input logic c);
    ena = e;
    fetch = f;
    data = d;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask
  initial begin
    tbl[0]  = '{0, 1, 2'b01, 8'hB4, 0, 3'b101, 13'h1400, 1, 0, 0};
    tbl[1]  = '{0, 1, 2'b10, 8'h5A, 0, 3'b101, 13'h145A, 1, 1, 0};
    tbl[2]  = '{0, 1, 2'b01, 8'h3F, 0, 3'b001, 13'h1F5A, 1, 0, 0};
    tbl[3]  = '{0, 1, 2'b10, 8'h00, 0, 3'b001, 13'h1F00, 1, 1, 0};
    tbl[4]  = '{0, 0, 2'b01, 8'hE0, 0, 3'b001, 13'h1F00, 1, 1, 0};
    tbl[5]  = '{0, 0, 2'b11, 8'hE0, 0, 3'b001, 13'h1F00, 1, 1, 0};
    tbl[6]  = '{0, 1, 2'b11, 8'hAA, 0, 3'b001, 13'h1F00, 1, 1, 1};
    tbl[7]  = '{0, 0, 2'b00, 8'h00, 1, 3'b001, 13'h1F00, 1, 1, 0};
    tbl[8]  = '{0, 1, 2'b00, 8'hC3, 0, 3'b001, 13'h1F00, 1, 1, 0};
    tbl[9]  = '{0, 1, 2'b01, 8'hE0, 0, 3'b111, 13'h0000, 1, 0, 0};
    tbl[10] = '{1, 1, 2'b10, 8'hFF, 0, 3'b000, 13'h0000, 0, 0, 1};
    tbl[11] = '{0, 1, 2'b11, 8'h00, 1, 3'b000, 13'h0000, 0, 0, 1};
    tbl[12] = '{0, 1, 2'b00, 8'h00, 1, 3'b000, 13'h0000, 0, 0, 0};
    tbl[13] = '{0, 1, 2'b01, 8'hFF, 0, 3'b111, 13'h1F00, 1, 0, 0};
    tbl[14] = '{0, 1, 2'b11, 8'hFF, 1, 3'b111, 13'h1F00, 1, 0, 1};
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 3'b000, 13'h0000, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b00, 8'h00, 1'b0);
      chk_all($sformatf("idle%0d", i), 3'b000, 13'h0000, 0, 0, 0);
    end
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rs) pulse_rst();
      step(tbl[i].ena, tbl[i].fetch, tbl[i].data, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].e_ins, tbl[i].e_addr, tbl[i].e_iv, tbl[i].e_av, tbl[i].e_err);
    end
    step(1'b1, 2'b01, 8'h7B, 1'b0);
    chk_all("midop_half", 3'b011, 13'h1B00, 1, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 3'b000, 13'h0000, 0, 0, 0);
    fetch = 2'b00;
    #1;
    rst = 1'b1;
    step(1'b1, 2'b00, 8'h00, 1'b0);
    chk_all("post_rst", 3'b000, 13'h0000, 0, 0, 0);
`ifdef IFR_INSTR_COUNT_EN
    chk("cnt_reset", 32'(instr_cnt), 32'd0);
    step(1'b0, 2'b01, 8'hE0, 1'b0);
    chk("cnt_gated", 32'(instr_cnt), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'b01, 8'h20, 1'b0);
      chk($sformatf("cnt_load%0d", i), 32'(instr_cnt), 32'(i % 4));
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
